// File: rtl/mem_copy_engine_if.sv
// Memory-side bus of the copy engine: address, write enable, write data out,
// combinational read data back.
interface mem_copy_engine_if #(
   parameter int W = 8,
   parameter int A = 8
);
   logic [A-1:0] MemAddress;
   logic         MemWriteEn;
   logic [W-1:0] MemDataIn;
   logic [W-1:0] MemDataOut;

   modport master (
      output MemAddress,
      output MemWriteEn,
      output MemDataIn,
      input  MemDataOut
   );

   modport slave (
      input  MemAddress,
      input  MemWriteEn,
      input  MemDataIn,
      output MemDataOut
   );
endinterface

// File: rtl/mem_copy_engine.sv
// Bulk word copier for a single-port memory: alternating READ/WRITE per word.
// Optional running sum of the words read: define MEM_COPY_CHECKSUM_EN.
module mem_copy_engine #(
   parameter int W = 8,
   parameter int A = 8
) (
   input  logic         clk,
   input  logic         Reset,
   input  logic         Start,
   input  logic [A-1:0] SrcAddr,
   input  logic [A-1:0] DstAddr,
   input  logic [A-1:0] Len,
   output logic         Busy,
   output logic         Done,
`ifdef MEM_COPY_CHECKSUM_EN
   output logic [W-1:0] Checksum,
`endif
   mem_copy_engine_if.master mem
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t       state_reg, state_next;
   logic [A-1:0] src_ptr_reg, src_ptr_next;
   logic [A-1:0] dst_ptr_reg, dst_ptr_next;
   logic [A-1:0] count_reg, count_next;
   logic [W-1:0] hold_reg, hold_next;
`ifdef MEM_COPY_CHECKSUM_EN
   logic [W-1:0] sum_reg, sum_next;
`endif

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         state_reg   <= IDLE;
         src_ptr_reg <= '0;
         dst_ptr_reg <= '0;
         count_reg   <= '0;
         hold_reg    <= '0;
`ifdef MEM_COPY_CHECKSUM_EN
         sum_reg     <= '0;
`endif
      end else begin
         state_reg   <= state_next;
         src_ptr_reg <= src_ptr_next;
         dst_ptr_reg <= dst_ptr_next;
         count_reg   <= count_next;
         hold_reg    <= hold_next;
`ifdef MEM_COPY_CHECKSUM_EN
         sum_reg     <= sum_next;
`endif
      end
   end

   always_comb begin
      state_next     = state_reg;
      src_ptr_next   = src_ptr_reg;
      dst_ptr_next   = dst_ptr_reg;
      count_next     = count_reg;
      hold_next      = hold_reg;
`ifdef MEM_COPY_CHECKSUM_EN
      sum_next       = sum_reg;
`endif
      mem.MemAddress = '0;
      mem.MemWriteEn = 1'b0;
      Busy           = 1'b0;
      Done           = 1'b0;

      case (state_reg)
         IDLE: begin
            if (Start) begin
               src_ptr_next = SrcAddr;
               dst_ptr_next = DstAddr;
               count_next   = Len;
`ifdef MEM_COPY_CHECKSUM_EN
               sum_next     = '0;
`endif
               state_next   = (Len != '0) ? READ : DONE;
            end
         end
         READ: begin
            Busy           = 1'b1;
            mem.MemAddress = src_ptr_reg;
            hold_next      = mem.MemDataOut;
            src_ptr_next   = src_ptr_reg + A'(1);
`ifdef MEM_COPY_CHECKSUM_EN
            sum_next       = sum_reg + mem.MemDataOut;
`endif
            state_next     = WRITE;
         end
         WRITE: begin
            Busy           = 1'b1;
            mem.MemAddress = dst_ptr_reg;
            mem.MemWriteEn = 1'b1;
            dst_ptr_next   = dst_ptr_reg + A'(1);
            count_next     = count_reg - A'(1);
            state_next     = (count_reg == A'(1)) ? DONE : READ;
         end
         DONE: begin
            Done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Write data tracks the holding register at all times, not only in WRITE.
   assign mem.MemDataIn = hold_reg;
`ifdef MEM_COPY_CHECKSUM_EN
   assign Checksum = sum_reg;
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed + randomized bench for mem_copy_engine with a behavioural memory
// and a forward word-by-word copy model.
module tb_mem_copy_engine;

   logic       clk = 1'b0;
   logic       Reset;
   logic       Start;
   logic [7:0] SrcAddr, DstAddr, Len;
   logic       Busy, Done;
`ifdef MEM_COPY_CHECKSUM_EN
   logic [7:0] Checksum;
`endif

   mem_copy_engine_if #(.W(8), .A(8)) bus ();

   mem_copy_engine #(.W(8), .A(8)) dut (
      .clk     (clk),
      .Reset   (Reset),
      .Start   (Start),
      .SrcAddr (SrcAddr),
      .DstAddr (DstAddr),
      .Len     (Len),
      .Busy    (Busy),
      .Done    (Done),
`ifdef MEM_COPY_CHECKSUM_EN
      .Checksum(Checksum),
`endif
      .mem     (bus.master)
   );

   always #5 clk = ~clk;

   // Behavioural memory: combinational read, synchronous write, plus a preload port.
   logic [7:0] mem [256];
   logic [7:0] refm [256];
   logic       pre_we = 1'b0;
   logic [7:0] pre_addr = 8'h00;
   logic [7:0] pre_data = 8'h00;

   assign bus.MemDataOut = mem[bus.MemAddress];

   always @(posedge clk) begin
      if (bus.MemWriteEn) mem[bus.MemAddress] <= bus.MemDataIn;
      else if (pre_we)    mem[pre_addr] <= pre_data;
   end

   int total = 0;
   int bad   = 0;
   logic [7:0] exp_sum;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic poke(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      pre_we = 1'b1; pre_addr = a; pre_data = d;
      refm[a] = d;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   task automatic check_mem(input string tag);
      int mism = 0;
      for (int i = 0; i < 256; i++)
         if (mem[i] !== refm[i]) mism++;
      check(tag, mism, 0);
   endtask

   // Reference: forward copy, each word read just before it is written.
   task automatic model_copy(input logic [7:0] s, input logic [7:0] d, input int n);
      logic [7:0] si, di;
      exp_sum = 8'h00;
      for (int i = 0; i < n; i++) begin
         si = s + 8'(i);
         di = d + 8'(i);
         exp_sum = exp_sum + refm[si];
         refm[di] = refm[si];
      end
   endtask

   task automatic run_copy(input string tag, input logic [7:0] s, input logic [7:0] d,
                           input logic [7:0] l, input bit glitch);
      int cyc, busy_n, we_n;
      bit got;
      model_copy(s, d, int'(l));
      @(negedge clk);
      Start = 1'b1; SrcAddr = s; DstAddr = d; Len = l;
      @(negedge clk);
      Start = 1'b0; SrcAddr = 8'($urandom); DstAddr = 8'($urandom); Len = 8'($urandom);
      cyc = 1; busy_n = 0; we_n = 0; got = 1'b0;
      while (cyc < 600) begin
         if (Done) begin got = 1'b1; break; end
         busy_n += int'(Busy);
         we_n   += int'(bus.MemWriteEn);
         if (glitch && cyc == 3) begin
            Start = 1'b1; SrcAddr = 8'h00; DstAddr = 8'h00; Len = 8'd5;
         end else Start = 1'b0;
         @(negedge clk);
         cyc++;
      end
      Start = 1'b0;
      check({tag, ":done_seen"}, 32'(got), 1);
      check({tag, ":latency"}, cyc, 2 * int'(l) + 1);
      check({tag, ":busy_cycles"}, busy_n, 2 * int'(l));
      check({tag, ":we_cycles"}, we_n, int'(l));
      @(negedge clk);
      check({tag, ":done_pulse"}, {31'b0, Done}, 0);
      check({tag, ":idle_busy"}, {31'b0, Busy}, 0);
`ifdef MEM_COPY_CHECKSUM_EN
      check({tag, ":checksum"}, Checksum, exp_sum);
`endif
      check_mem({tag, ":memory"});
      $display("copy %s src=%02h dst=%02h len=%0d cycles=%0d", tag, s, d, l, cyc);
   endtask

   initial begin
      Reset = 1'b0; Start = 1'b0; SrcAddr = 8'h00; DstAddr = 8'h00; Len = 8'h00;
      #1;
      check("rst:busy", {31'b0, Busy}, 0);
      check("rst:done", {31'b0, Done}, 0);
      check("rst:we", {31'b0, bus.MemWriteEn}, 0);
      check("rst:addr", bus.MemAddress, 0);
      check("rst:wdata", bus.MemDataIn, 0);
`ifdef MEM_COPY_CHECKSUM_EN
      check("rst:checksum", Checksum, 0);
`endif
      for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
      @(negedge clk);
      Reset = 1'b1;

      poke(8'h10, 8'hAA); poke(8'h11, 8'hBB); poke(8'h12, 8'hCC); poke(8'h13, 8'hDD);
      run_copy("basic", 8'h10, 8'h80, 8'd4, 1'b0);
`ifdef MEM_COPY_CHECKSUM_EN
      check("basic:checksum_0e", Checksum, 8'h0E);
`endif
      run_copy("len0", 8'h33, 8'h44, 8'd0, 1'b0);

      poke(8'hFE, 8'h01); poke(8'hFF, 8'h02); poke(8'h00, 8'h03);
      run_copy("wrap", 8'hFE, 8'h40, 8'd3, 1'b0);
      check("wrap:dst42", mem[8'h42], 8'h03);

      poke(8'h20, 8'h11);
      run_copy("overlap", 8'h20, 8'h21, 8'd3, 1'b0);
      check("overlap:dst23", mem[8'h23], 8'h11);

      run_copy("ignore_start", 8'h60, 8'hA0, 8'd4, 1'b1);

      // Abort a Len=4 copy in the READ cycle following its second write.
      model_copy(8'h50, 8'h90, 2);
      @(negedge clk);
      Start = 1'b1; SrcAddr = 8'h50; DstAddr = 8'h90; Len = 8'd4;
      @(negedge clk);
      Start = 1'b0;
      repeat (4) @(negedge clk);
      Reset = 1'b0;
      #1;
      check("abort:busy", {31'b0, Busy}, 0);
      check("abort:we", {31'b0, bus.MemWriteEn}, 0);
      check("abort:addr", bus.MemAddress, 0);
      check("abort:wdata", bus.MemDataIn, 0);
      check("abort:done", {31'b0, Done}, 0);
      @(negedge clk);
      Reset = 1'b1;
      check_mem("abort:memory");
      $display("copy abort src=50 dst=90 len=4 reset after two writes");
      run_copy("after_abort", 8'h50, 8'h90, 8'd4, 1'b0);

      for (int t = 0; t < 8; t++)
         run_copy("random", 8'($urandom), 8'($urandom), 8'($urandom_range(1, 24)), 1'b0);
      run_copy("random_long", 8'($urandom), 8'($urandom), 8'($urandom_range(100, 255)), 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
